// File: rtl/viterbi_ber_checker.sv
// BER monitor for the Viterbi loopback: finds decoder latency against a source-bit
// history, then counts compared bits and errors and drops lock on dense errors.
module viterbi_ber_checker #(
  parameter  int MAX_LAT  = 64,
  parameter  int LOCK_WIN = 32,
  parameter  int WIN_LEN  = 64,
  parameter  int LOSS_THR = 8,
  parameter  int CNT_W    = 32,
  localparam int LAT_W    = $clog2(MAX_LAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             ref_i,
  input  logic             ref_valid_i,
  input  logic             dec_i,
  input  logic             dec_valid_i,
  output logic             locked_o,
  output logic [LAT_W-1:0] lat_o,
  output logic [CNT_W-1:0] bit_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             err_o,
  output logic             loss_o
);

  localparam int MC_W = $clog2(LOCK_WIN + 1);
  localparam int WC_W = $clog2(WIN_LEN + 1);
  localparam int WE_W = $clog2(LOSS_THR + 1);
  localparam logic [MC_W-1:0] LOCK_LAST = MC_W'(LOCK_WIN - 1);
  localparam logic [WC_W-1:0] WIN_LAST  = WC_W'(WIN_LEN - 1);
  localparam logic [WE_W-1:0] LOSS_LAST = WE_W'(LOSS_THR - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state, state_n;
  logic [MAX_LAT-1:0] hist;
  logic [LAT_W-1:0] lat, lat_n;
  logic [MC_W-1:0]  match_cnt, match_cnt_n;
  logic [WC_W-1:0]  win_cnt, win_cnt_n;
  logic [WE_W-1:0]  win_err, win_err_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n, err_cnt, err_cnt_n;
  logic             err_n, loss, loss_n;
  logic             match;

  // hist[0] is the newest source bit; the compare reads it before this cycle's shift
  assign match = (dec_i == hist[lat]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= '0;
    else if (ref_valid_i) hist <= {hist[MAX_LAT-2:0], ref_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      lat       <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      bit_cnt   <= '0;
      err_cnt   <= '0;
      err_o     <= 1'b0;
      loss      <= 1'b0;
    end else begin
      state     <= state_n;
      lat       <= lat_n;
      match_cnt <= match_cnt_n;
      win_cnt   <= win_cnt_n;
      win_err   <= win_err_n;
      bit_cnt   <= bit_cnt_n;
      err_cnt   <= err_cnt_n;
      err_o     <= err_n;
      loss      <= loss_n;
    end
  end

  always_comb begin
    state_n     = state;
    lat_n       = lat;
    match_cnt_n = match_cnt;
    win_cnt_n   = win_cnt;
    win_err_n   = win_err;
    bit_cnt_n   = bit_cnt;
    err_cnt_n   = err_cnt;
    err_n       = 1'b0;
    loss_n      = loss;
    if (dec_valid_i) begin
      case (state)
        SEARCH: begin
          if (match) begin
            if (match_cnt == LOCK_LAST) begin
              state_n     = LOCKED;
              match_cnt_n = '0;
              win_cnt_n   = '0;
              win_err_n   = '0;
            end else begin
              match_cnt_n = match_cnt + MC_W'(1);
            end
          end else begin
            match_cnt_n = '0;
            lat_n       = lat + LAT_W'(1);
          end
        end
        LOCKED: begin
          if (bit_cnt != '1) bit_cnt_n = bit_cnt + CNT_W'(1);
          if (!match) begin
            err_n = 1'b1;
            if (err_cnt != '1) err_cnt_n = err_cnt + CNT_W'(1);
          end
          // loss outranks the end-of-window clear
          if (!match && win_err == LOSS_LAST) begin
            state_n     = SEARCH;
            loss_n      = 1'b1;
            lat_n       = lat + LAT_W'(1);
            match_cnt_n = '0;
            win_cnt_n   = '0;
            win_err_n   = '0;
          end else if (win_cnt == WIN_LAST) begin
            win_cnt_n = '0;
            win_err_n = '0;
          end else begin
            win_cnt_n = win_cnt + WC_W'(1);
            win_err_n = win_err + WE_W'(!match);
          end
        end
        default: state_n = SEARCH;
      endcase
    end
    if (clear_i) begin
      bit_cnt_n = '0;
      err_cnt_n = '0;
      loss_n    = 1'b0;
      win_cnt_n = '0;
      win_err_n = '0;
    end
  end

  assign locked_o  = (state == LOCKED);
  assign lat_o     = lat;
  assign bit_cnt_o = bit_cnt;
  assign err_cnt_o = err_cnt;
  assign loss_o    = loss;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Scoreboard bench for viterbi_ber_checker: emulates a decoder of known latency
// over a random source stream and checks lock, counters and err_o pulses.
module tb_viterbi_ber_checker;
  logic        clk = 1'b0;
  logic        rst, clear_i, ref_i, ref_valid_i, dec_i, dec_valid_i;
  logic        locked_o, err_o, loss_o;
  logic [5:0]  lat_o;
  logic [31:0] bit_cnt_o, err_cnt_o;
  logic        s_locked, s_err_o, s_loss;
  logic [5:0]  s_lat;
  logic [3:0]  s_bit, s_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit sent[$];
  bit exp_err[$];
  int dec_lat = 0;

  viterbi_ber_checker u_dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .ref_i(ref_i), .ref_valid_i(ref_valid_i),
    .dec_i(dec_i), .dec_valid_i(dec_valid_i), .locked_o(locked_o), .lat_o(lat_o),
    .bit_cnt_o(bit_cnt_o), .err_cnt_o(err_cnt_o), .err_o(err_o), .loss_o(loss_o));

  viterbi_ber_checker #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .clear_i(clear_i), .ref_i(ref_i), .ref_valid_i(ref_valid_i),
    .dec_i(dec_i), .dec_valid_i(dec_valid_i), .locked_o(s_locked), .lat_o(s_lat),
    .bit_cnt_o(s_bit), .err_cnt_o(s_err), .err_o(s_err_o), .loss_o(s_loss));

  always #5 clk = ~clk;

  // source bit pushed 'back' pushes before the newest one; 0 before the stream began
  function automatic bit src_at(input int back);
    int idx;
    idx = sent.size() - 1 - back;
    return (idx >= 0) ? sent[idx] : 1'b0;
  endfunction

  task automatic drive(input bit rv, input bit dv, input bit flip, input bit track);
    bit r;
    r = 1'($urandom_range(0, 1));
    ref_i       = r;
    ref_valid_i = rv;
    dec_valid_i = dv;
    dec_i       = src_at(dec_lat) ^ flip;
    if (track) exp_err.push_back(dv & flip);
    @(posedge clk);
    if (rv) sent.push_back(r);
    @(negedge clk);
    ref_valid_i = 1'b0;
    dec_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear_i = 1'b0; ref_i = 1'b0; ref_valid_i = 1'b0;
    dec_i = 1'b0; dec_valid_i = 1'b0;
    sent.delete();
    exp_err.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic acquire(input int budget, output bit ok);
    ok = 1'b0;
    for (int b = 0; b < budget && !ok; b++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      if (locked_o) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #1;
    n_tests++; if (locked_o !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked_o); end
    n_tests++; if (lat_o !== 6'd0) begin n_fail++; $display("FAIL reset_lat: got %0d want 0", lat_o); end
    n_tests++; if (bit_cnt_o !== 32'd0 || err_cnt_o !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bit_cnt_o, err_cnt_o); end
    n_tests++; if (err_o !== 1'b0 || loss_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got err=%b loss=%b want 0/0", err_o, loss_o); end
    n_tests++; if (s_bit !== 4'd0 || s_locked !== 1'b0) begin
      n_fail++; $display("FAIL reset_sat: got bit=%0d locked=%b want 0/0", s_bit, s_locked); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lock_lat20();
    bit ok, e;
    do_reset();
    dec_lat = 20;
    acquire(21*32+20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL lat20_lock: got locked=0 want 1"); end
    n_tests++; if (lat_o !== 6'd20) begin n_fail++; $display("FAIL lat20_lat: got %0d want 20", lat_o); end
    n_tests++; if (bit_cnt_o !== 32'd0) begin n_fail++; $display("FAIL lat20_cnt_at_lock: got %0d want 0", bit_cnt_o); end
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      e = exp_err.pop_front();
      n_tests++; if (err_o !== e) begin n_fail++; $display("FAIL lat20_err_o: bit %0d got %b want %b", i, err_o, e); end
    end
    n_tests++; if (bit_cnt_o !== 32'd1000) begin n_fail++; $display("FAIL lat20_bit_cnt: got %0d want 1000", bit_cnt_o); end
    n_tests++; if (err_cnt_o !== 32'd0) begin n_fail++; $display("FAIL lat20_err_cnt: got %0d want 0", err_cnt_o); end
    n_tests++; if (loss_o !== 1'b0 || locked_o !== 1'b1) begin
      n_fail++; $display("FAIL lat20_state: got loss=%b locked=%b want 0/1", loss_o, locked_o); end
  endtask

  task automatic test_errors();
    bit ok, e, flip, last;
    do_reset();
    dec_lat = 5;
    acquire(2000, ok);
    n_tests++; if (!ok || lat_o !== 6'd5) begin
      n_fail++; $display("FAIL err_lock: got locked=%b lat=%0d want 1/5", ok, lat_o); end
    // windows 0,1: 4 errors each; window 2: 7 errors; window 3: 8th error forces loss
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 64; i++) begin
        flip = (w < 2) ? (i % 16 == 15) : ((w == 2) ? (i < 7) : (i < 8));
        last = (w == 3 && i == 7);
        drive(1'b1, 1'b1, flip, 1'b1);
        e = exp_err.pop_front();
        n_tests++; if (err_o !== e) begin n_fail++; $display("FAIL err_pulse: w%0d i%0d got %b want %b", w, i, err_o, e); end
        if (!last) begin
          n_tests++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL err_hold: w%0d i%0d got locked=0 want 1", w, i); end
        end
        if (w < 2 && i == 63) begin
          n_tests++; if (err_cnt_o !== 32'(4*(w+1))) begin
            n_fail++; $display("FAIL err_window_cnt: got %0d want %0d", err_cnt_o, 4*(w+1)); end
        end
        if (last) break;
      end
    end
    n_tests++; if (locked_o !== 1'b0 || loss_o !== 1'b1) begin
      n_fail++; $display("FAIL err_loss: got locked=%b loss=%b want 0/1", locked_o, loss_o); end
    n_tests++; if (lat_o !== 6'd6) begin n_fail++; $display("FAIL err_loss_lat: got %0d want 6", lat_o); end
    n_tests++; if (err_cnt_o !== 32'd23 || bit_cnt_o !== 32'd200) begin
      n_fail++; $display("FAIL err_totals: got err=%0d bits=%0d want 23/200", err_cnt_o, bit_cnt_o); end
    clear_i = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    clear_i = 1'b0;
    n_tests++; if (loss_o !== 1'b0 || err_cnt_o !== 32'd0 || bit_cnt_o !== 32'd0) begin
      n_fail++; $display("FAIL err_clear: got loss=%b err=%0d bits=%0d want 0/0/0", loss_o, err_cnt_o, bit_cnt_o); end
    n_tests++; if (lat_o !== 6'd6 || locked_o !== 1'b0) begin
      n_fail++; $display("FAIL err_clear_keep: got lat=%0d locked=%b want 6/0", lat_o, locked_o); end
  endtask

  task automatic test_wrap_lat63();
    bit ok;
    do_reset();
    dec_lat = 63;
    acquire(3000, ok);
    n_tests++; if (!ok || lat_o !== 6'd63) begin
      n_fail++; $display("FAIL lat63: got locked=%b lat=%0d want 1/63", ok, lat_o); end
  endtask

  task automatic test_out_of_range();
    bit ever;
    bit bad_step;
    int wraps;
    logic [5:0] prev;
    do_reset();
    dec_lat = 64;
    ever = 1'b0; bad_step = 1'b0; wraps = 0; prev = 6'd0;
    for (int i = 0; i < 3000; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      if (locked_o) ever = 1'b1;
      if (lat_o != prev && lat_o != prev + 6'd1) bad_step = 1'b1;
      if (prev == 6'd63 && lat_o == 6'd0) wraps++;
      prev = lat_o;
    end
    n_tests++; if (ever) begin n_fail++; $display("FAIL lat64_nolock: got locked=1 want 0"); end
    n_tests++; if (wraps < 2) begin n_fail++; $display("FAIL lat64_wraps: got %0d want >=2", wraps); end
    n_tests++; if (bad_step) begin n_fail++; $display("FAIL lat64_step: got non-unit lat step want +1"); end
  endtask

  task automatic test_gapped();
    bit ok, e, rv, dv;
    do_reset();
    dec_lat = 9;
    ok = 1'b0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      rv = ($urandom_range(0, 99) >= 30);
      dv = ($urandom_range(0, 99) >= 30);
      drive(rv, dv, 1'b0, 1'b0);
      if (locked_o) ok = 1'b1;
    end
    n_tests++; if (!ok || lat_o !== 6'd9) begin
      n_fail++; $display("FAIL gap_lock: got locked=%b lat=%0d want 1/9", ok, lat_o); end
    for (int c = 0; c < 300; c++) begin
      rv = ($urandom_range(0, 99) >= 30);
      dv = ($urandom_range(0, 99) >= 30);
      drive(rv, dv, 1'b0, 1'b1);
      e = exp_err.pop_front();
      n_tests++; if (err_o !== e) begin n_fail++; $display("FAIL gap_err_o: cyc %0d got %b want %b", c, err_o, e); end
    end
    n_tests++; if (err_cnt_o !== 32'd0 || locked_o !== 1'b1) begin
      n_fail++; $display("FAIL gap_final: got err=%0d locked=%b want 0/1", err_cnt_o, locked_o); end
  endtask

  task automatic test_saturate_clear();
    n_tests++; if (s_bit !== 4'd15 || s_locked !== 1'b1) begin
      n_fail++; $display("FAIL sat_stop: got bit=%0d locked=%b want 15/1", s_bit, s_locked); end
    clear_i = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    clear_i = 1'b0;
    n_tests++; if (bit_cnt_o !== 32'd0 || err_cnt_o !== 32'd0 || s_bit !== 4'd0) begin
      n_fail++; $display("FAIL clr_cnt: got bits=%0d err=%0d sat=%0d want 0/0/0", bit_cnt_o, err_cnt_o, s_bit); end
    n_tests++; if (loss_o !== 1'b0 || locked_o !== 1'b1 || lat_o !== 6'd9) begin
      n_fail++; $display("FAIL clr_keep: got loss=%b locked=%b lat=%0d want 0/1/9", loss_o, locked_o, lat_o); end
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++; if (bit_cnt_o !== 32'd20 || s_bit !== 4'd15) begin
      n_fail++; $display("FAIL sat_again: got bits=%0d sat=%0d want 20/15", bit_cnt_o, s_bit); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    rst = 1'b1;
    #1;
    n_tests++; if (locked_o !== 1'b0 || lat_o !== 6'd0) begin
      n_fail++; $display("FAIL rst_mid_state: got locked=%b lat=%0d want 0/0", locked_o, lat_o); end
    n_tests++; if (bit_cnt_o !== 32'd0 || err_cnt_o !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_cnt: got %0d/%0d want 0/0", bit_cnt_o, err_cnt_o); end
    @(negedge clk);
    rst = 1'b0;
    sent.delete();
    dec_lat = 20;
    acquire(21*32+20, ok);
    n_tests++; if (!ok || lat_o !== 6'd20) begin
      n_fail++; $display("FAIL rst_mid_relock: got locked=%b lat=%0d want 1/20", ok, lat_o); end
  endtask

  initial begin
    test_reset();
    test_lock_lat20();
    test_errors();
    test_wrap_lat63();
    test_out_of_range();
    test_gapped();
    test_saturate_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
